// File: rtl/fifo_read_packer.sv
// Read-domain consumer for the dual-clock FIFO: packs RATIO consecutive DSIZE-bit
// words into one wide valid/ready beat, with flush-driven partial beats and lane keep.
module fifo_read_packer #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic                   rempty,
    input  logic [DSIZE-1:0]       rdata,
    output logic                   rinc,
    input  logic                   flush,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DSIZE*RATIO-1:0] m_data,
    output logic [RATIO-1:0]       m_keep
);

    localparam int BW = DSIZE * RATIO;
    localparam int LW = $clog2(RATIO);
    localparam logic [LW-1:0] LAST = LW'(RATIO - 1);

    logic [BW-1:0] acc;
    logic [LW-1:0] lane_cnt;
    logic          flush_pend;
    logic          out_free;
    logic          flush_go;

    function automatic logic [RATIO-1:0] keep_mask(input logic [LW-1:0] cnt);
        logic [RATIO-1:0] m;
        m = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (i < int'(cnt)) m[i] = 1'b1;
        end
        return m;
    endfunction

    // A flush takes the cycle for itself, so it never races a pop into the same beat.
    always_comb begin
        out_free = !m_valid || m_ready;
        flush_go = flush_pend && (lane_cnt != '0) && out_free;
        rinc     = !rrst && !rempty && !flush_go && ((lane_cnt != LAST) || out_free);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            acc        <= '0;
            lane_cnt   <= '0;
            flush_pend <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
        end else begin
            if (m_valid && m_ready) m_valid <= 1'b0;

            if (rinc) begin
                if (lane_cnt == LAST) begin
                    m_data   <= {rdata, acc[BW-DSIZE-1:0]};
                    m_keep   <= '1;
                    m_valid  <= 1'b1;
                    acc      <= '0;
                    lane_cnt <= '0;
                end else begin
                    acc[lane_cnt*DSIZE +: DSIZE] <= rdata;
                    lane_cnt <= lane_cnt + 1'b1;
                end
            end else if (flush_go) begin
                m_data   <= acc;
                m_keep   <= keep_mask(lane_cnt);
                m_valid  <= 1'b1;
                acc      <= '0;
                lane_cnt <= '0;
            end

            // A pending flush survives an empty accumulator only while words keep arriving.
            if (flush_go) begin
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end else if ((lane_cnt == '0) && !rinc) begin
                flush_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_packer.sv
// Bench for fifo_read_packer: queue-modelled FIFO, beat scoreboard, table vectors
// plus hand-written back-pressure, stall, flush-corner and reset sequences.
module tb_fifo_read_packer;

    localparam int DSIZE = 8;
    localparam int RATIO = 4;

    logic        clk = 1'b0;
    logic        rrst = 1'b1;
    logic        rempty = 1'b1;
    logic [7:0]  rdata = 8'h00;
    logic        rinc;
    logic        flush = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [3:0]  m_keep;

    always #5 clk = ~clk;

    fifo_read_packer #(.DSIZE(DSIZE), .RATIO(RATIO)) dut (
        .rclk(clk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
    } beat_t;

    typedef struct {
        logic [31:0] words;
        int          n;
        bit          do_flush;
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
    } vec_t;

    logic [7:0]  fifo_q[$];
    beat_t       sb[$];
    vec_t        vecs[5];
    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    bit          stall = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    logic [3:0]  prev_keep = '0;

    function void drive_fifo();
        rempty = (fifo_q.size() == 0) || stall;
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endfunction

    task push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    task expect_beat(input logic [31:0] d, input logic [3:0] k);
        beat_t b;
        b.data = d;
        b.keep = k;
        sb.push_back(b);
    endtask

    task check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task step();
        bit    pop_now;
        beat_t b;
        @(negedge clk);
        checks++;
        if (rinc && (rempty || rrst)) begin
            errors++;
            $display("FAIL rinc_guard: rinc=1 with rempty=%b rrst=%b", rempty, rrst);
        end
        if (prev_hold) begin
            checks++;
            if (!m_valid || m_data !== prev_data || m_keep !== prev_keep) begin
                errors++;
                $display("FAIL hold_stable: got v=%b %h/%b expected v=1 %h/%b",
                         m_valid, m_data, m_keep, prev_data, prev_keep);
            end
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
        prev_keep = m_keep;
        if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h/%b expected no beat", m_data, m_keep);
            end else begin
                b = sb.pop_front();
                check("beat_data", m_data, b.data);
                check("beat_keep", {28'd0, m_keep}, {28'd0, b.keep});
            end
        end
        pop_now = rinc;
        @(posedge clk);
        #1;
        if (pop_now && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        flush = 1'b0;
        drive_fifo();
    endtask

    task run_until_empty(input int maxc, input string name);
        int n;
        n = 0;
        while (fifo_q.size() != 0 && n < maxc) begin
            step();
            n++;
        end
        check(name, fifo_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{32'h44332211, 4, 1'b0, 32'h44332211, 4'b1111};
        vecs[1] = '{32'h0000B2A1, 2, 1'b1, 32'h0000B2A1, 4'b0011};
        vecs[2] = '{32'h000000C3, 1, 1'b1, 32'h000000C3, 4'b0001};
        vecs[3] = '{32'h00030201, 3, 1'b1, 32'h00030201, 4'b0111};
        vecs[4] = '{32'hEFBEADDE, 4, 1'b0, 32'hEFBEADDE, 4'b1111};

        drive_fifo();
        rrst = 1'b1;
        repeat (3) step();
        check("reset_m_valid", m_valid, 0);
        check("reset_m_data", m_data, 0);
        check("reset_m_keep", m_keep, 0);
        check("reset_rinc", rinc, 0);
        rrst = 1'b0;
        step();

        // Table vectors: full beats and flushed partial beats with ready held high
        m_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            pops = 0;
            for (int i = 0; i < vecs[v].n; i++) push_word(vecs[v].words[i*8 +: 8]);
            expect_beat(vecs[v].exp_data, vecs[v].exp_keep);
            run_until_empty(20, "vec_drain");
            check("vec_pops", pops, vecs[v].n);
            if (vecs[v].do_flush) flush = 1'b1;
            repeat (4) step();
            check("vec_beat_seen", sb.size(), 0);
        end

        // Back-pressure: first beat held, exactly three further pops, then stall
        m_ready = 1'b0;
        pops = 0;
        for (int w = 1; w <= 8; w++) push_word(8'(w));
        expect_beat(32'h04030201, 4'b1111);
        expect_beat(32'h08070605, 4'b1111);
        repeat (14) step();
        check("bp_pops", pops, 7);
        check("bp_left", fifo_q.size(), 1);
        check("bp_valid", m_valid, 1);
        check("bp_held_data", m_data, 32'h04030201);
        check("bp_rinc_low", rinc, 0);
        m_ready = 1'b1;
        step();
        check("bp_second_valid", m_valid, 1);
        check("bp_second_data", m_data, 32'h08070605);
        repeat (3) step();
        check("bp_sb_empty", sb.size(), 0);
        check("bp_fifo_empty", fifo_q.size(), 0);

        // Empty flag toggling every cycle
        for (int w = 0; w < 8; w++) push_word(8'h10 + 8'(w));
        expect_beat(32'h13121110, 4'b1111);
        expect_beat(32'h17161514, 4'b1111);
        for (int c = 0; c < 30; c++) begin
            stall = c[0];
            drive_fifo();
            step();
        end
        stall = 1'b0;
        drive_fifo();
        check("stall_sb_empty", sb.size(), 0);
        check("stall_fifo_empty", fifo_q.size(), 0);

        // Flush with nothing accumulated emits nothing
        flush = 1'b1;
        repeat (5) step();
        check("flush0_no_beat", m_valid, 0);

        // Flush coincident with a completing pop carries over to the next partial beat
        m_ready = 1'b0;
        push_word(8'h31);
        push_word(8'h32);
        push_word(8'h33);
        run_until_empty(10, "coin_drain3");
        expect_beat(32'h34333231, 4'b1111);
        expect_beat(32'h00003635, 4'b0011);
        push_word(8'h34);
        flush = 1'b1;
        step();
        check("coin_full_valid", m_valid, 1);
        push_word(8'h35);
        push_word(8'h36);
        run_until_empty(10, "coin_drain2");
        repeat (3) step();
        check("coin_held_data", m_data, 32'h34333231);
        m_ready = 1'b1;
        repeat (4) step();
        check("coin_sb_empty", sb.size(), 0);
        check("coin_no_extra", m_valid, 0);

        // Reset mid-beat discards the partial accumulation
        push_word(8'h41);
        push_word(8'h42);
        run_until_empty(10, "rst_drain2");
        rrst = 1'b1;
        for (int w = 1; w <= 4; w++) push_word(8'h50 + 8'(w));
        repeat (2) step();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_keep", m_keep, 0);
        check("rst_words_kept", fifo_q.size(), 4);
        rrst = 1'b0;
        expect_beat(32'h54535251, 4'b1111);
        run_until_empty(10, "rst_drain4");
        repeat (3) step();
        check("rst_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
